dsp_engine_sequencer: RTL and testbench

- Sequences the shared-DSP-clock filter engines (Kalman, Resonant, and later engines) once per control period.
- On each period start pulse it launches every unmasked engine in turn, lowest index first, and waits for each to finish.
- Only the active engine's Mem2 write port is forwarded to the single result memory, through a registered mux.
- Sits in the clk_DSP domain, between the period-sync logic and the engine bank.

---
 rtl/dsp_engine_sequencer.sv | 226 ++++++++++++++++++++++
 tb/tb_dsp_engine_sequencer.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dsp_engine_sequencer.sv
// Runs each unmasked DSP filter engine once per control period, lowest slot
// first, and forwards only the active engine's Mem2 writes to the result memory.
module dsp_engine_sequencer #(
    parameter int unsigned ENGINES  = 2,
    parameter int unsigned ACK_WAIT = 8,
    parameter int unsigned TIMEOUT  = 4095,
    parameter int unsigned ADDR_W   = 9,
    parameter int unsigned DATA_W   = 36
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      start_i,
    input  logic [ENGINES-1:0]        mask_i,
    input  logic                      clear_i,
    input  logic [ENGINES-1:0]        wip_i,
    output logic [ENGINES-1:0]        enable_o,
    input  logic [ENGINES-1:0]        mem2_we_i,
    input  logic [ENGINES*ADDR_W-1:0] mem2_addr_i,
    input  logic [ENGINES*DATA_W-1:0] mem2_data_i,
    output logic                      mem_we_o,
    output logic [ADDR_W-1:0]         mem_addr_o,
    output logic [DATA_W-1:0]         mem_data_o,
    output logic                      busy_o,
    output logic                      done_o,
    output logic                      overrun_o,
    output logic [ENGINES-1:0]        ack_err_o,
    output logic [ENGINES-1:0]        timeout_o
);
    localparam int unsigned SLOT_W  = $clog2(ENGINES + 1);
    localparam int unsigned CNT_MAX = (ACK_WAIT > TIMEOUT) ? ACK_WAIT : TIMEOUT;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 2);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_SELECT = 3'd1,
        S_LAUNCH = 3'd2,
        S_RUN    = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [SLOT_W-1:0]   r_slot;
    logic [SLOT_W-1:0]   w_slot_nxt;
    logic [CNT_W-1:0]    r_cnt;
    logic [CNT_W-1:0]    w_cnt_nxt;
    logic [CNT_W-1:0]    w_cnt_inc;
    logic [ENGINES-1:0]  r_run_mask;
    logic [ENGINES-1:0]  w_mask_nxt;
    logic [ENGINES-1:0]  w_ack_set;
    logic [ENGINES-1:0]  w_to_set;

    logic [ENGINES-1:0]  r_enable;
    logic                r_busy;
    logic                r_done;
    logic                r_overrun;
    logic [ENGINES-1:0]  r_ack_err;
    logic [ENGINES-1:0]  r_timeout;
    logic                r_mem_we;
    logic [ADDR_W-1:0]   r_mem_addr;
    logic [DATA_W-1:0]   r_mem_data;

    logic [ENGINES-1:0]  w_enable_nxt;
    logic                w_busy_nxt;
    logic                w_done_nxt;
    logic                w_overrun_nxt;
    logic [ENGINES-1:0]  w_ack_err_nxt;
    logic [ENGINES-1:0]  w_timeout_nxt;
    logic                w_fwd;
    logic [ADDR_W-1:0]   w_mem_addr_nxt;
    logic [DATA_W-1:0]   w_mem_data_nxt;

    logic [ENGINES-1:0]  w_slot_oh;
    logic                w_sel_mask;
    logic                w_sel_wip;
    logic                w_sel_we;
    logic [ADDR_W-1:0]   w_sel_addr;
    logic [DATA_W-1:0]   w_sel_data;

    // Decode the current slot; slot == ENGINES (end of sweep) selects nothing.
    always_comb begin
        w_slot_oh  = '0;
        w_sel_addr = '0;
        w_sel_data = '0;
        for (int k = 0; k < ENGINES; k++) begin
            if (r_slot == SLOT_W'(k)) begin
                w_slot_oh[k] = 1'b1;
                w_sel_addr   = mem2_addr_i[k*ADDR_W +: ADDR_W];
                w_sel_data   = mem2_data_i[k*DATA_W +: DATA_W];
            end
        end
    end

    assign w_sel_mask = |(r_run_mask & w_slot_oh);
    assign w_sel_wip  = |(wip_i & w_slot_oh);
    assign w_sel_we   = |(mem2_we_i & w_slot_oh);
    assign w_cnt_inc  = r_cnt + CNT_W'(1);

    // State register and sequencing counters.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state    <= S_IDLE;
            r_slot     <= '0;
            r_cnt      <= '0;
            r_run_mask <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_slot     <= w_slot_nxt;
            r_cnt      <= w_cnt_nxt;
            r_run_mask <= w_mask_nxt;
        end
    end

    // Next-state logic; WIP is checked before the counter so a fall on the
    // last allowed cycle is a clean finish, not a timeout.
    always_comb begin
        w_state_nxt = r_state;
        w_slot_nxt  = r_slot;
        w_cnt_nxt   = r_cnt;
        w_mask_nxt  = r_run_mask;
        w_ack_set   = '0;
        w_to_set    = '0;
        case (r_state)
            S_IDLE: begin
                if (start_i) begin
                    w_mask_nxt  = mask_i;
                    w_slot_nxt  = '0;
                    w_state_nxt = S_SELECT;
                end
            end
            S_SELECT: begin
                if (r_slot == SLOT_W'(ENGINES)) begin
                    w_state_nxt = S_DONE;
                end else if (!w_sel_mask) begin
                    w_slot_nxt = r_slot + SLOT_W'(1);
                end else begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = S_LAUNCH;
                end
            end
            S_LAUNCH: begin
                w_cnt_nxt = w_cnt_inc;
                if (w_sel_wip) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = S_RUN;
                end else if (w_cnt_inc >= CNT_W'(ACK_WAIT)) begin
                    w_ack_set   = w_slot_oh;
                    w_slot_nxt  = r_slot + SLOT_W'(1);
                    w_state_nxt = S_SELECT;
                end
            end
            S_RUN: begin
                w_cnt_nxt = w_cnt_inc;
                if (!w_sel_wip) begin
                    w_slot_nxt  = r_slot + SLOT_W'(1);
                    w_state_nxt = S_SELECT;
                end else if (w_cnt_inc >= CNT_W'(TIMEOUT)) begin
                    w_to_set    = w_slot_oh;
                    w_slot_nxt  = r_slot + SLOT_W'(1);
                    w_state_nxt = S_SELECT;
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Output logic: values the output registers take on the coming edge.
    always_comb begin
        w_enable_nxt = '0;
        if (w_state_nxt == S_LAUNCH || w_state_nxt == S_RUN) begin
            w_enable_nxt = w_slot_oh;
        end
        w_busy_nxt = (w_state_nxt == S_SELECT) || (w_state_nxt == S_LAUNCH) ||
                     (w_state_nxt == S_RUN);
        w_done_nxt = (w_state_nxt == S_DONE);

        w_fwd          = ((r_state == S_LAUNCH) || (r_state == S_RUN)) && w_sel_we;
        w_mem_addr_nxt = w_fwd ? w_sel_addr : r_mem_addr;
        w_mem_data_nxt = w_fwd ? w_sel_data : r_mem_data;

        w_overrun_nxt = (r_overrun & ~clear_i) | (start_i & (r_state != S_IDLE));
        w_ack_err_nxt = (r_ack_err & ~{ENGINES{clear_i}}) | w_ack_set;
        w_timeout_nxt = (r_timeout & ~{ENGINES{clear_i}}) | w_to_set;
    end

    // Registered outputs.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_enable   <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_overrun  <= 1'b0;
            r_ack_err  <= '0;
            r_timeout  <= '0;
            r_mem_we   <= 1'b0;
            r_mem_addr <= '0;
            r_mem_data <= '0;
        end else begin
            r_enable   <= w_enable_nxt;
            r_busy     <= w_busy_nxt;
            r_done     <= w_done_nxt;
            r_overrun  <= w_overrun_nxt;
            r_ack_err  <= w_ack_err_nxt;
            r_timeout  <= w_timeout_nxt;
            r_mem_we   <= w_fwd;
            r_mem_addr <= w_mem_addr_nxt;
            r_mem_data <= w_mem_data_nxt;
        end
    end

    assign enable_o   = r_enable;
    assign busy_o     = r_busy;
    assign done_o     = r_done;
    assign overrun_o  = r_overrun;
    assign ack_err_o  = r_ack_err;
    assign timeout_o  = r_timeout;
    assign mem_we_o   = r_mem_we;
    assign mem_addr_o = r_mem_addr;
    assign mem_data_o = r_mem_data;

endmodule

// File: tb/tb_dsp_engine_sequencer.sv
// Bench for dsp_engine_sequencer: engine timelines are planned arithmetically
// per sequence and every output is compared on every cycle.
module tb_dsp_engine_sequencer;
    localparam int ENGINES  = 2;
    localparam int ACK_WAIT = 8;
    localparam int TIMEOUT  = 50;
    localparam int ADDR_W   = 9;
    localparam int DATA_W   = 36;
    localparam int NEVER    = 1000;

    logic                      clk;
    logic                      rst;
    logic                      start;
    logic [1:0]                mask;
    logic                      clear;
    logic [1:0]                wip;
    logic [1:0]                enable;
    logic [1:0]                we;
    logic [ENGINES*ADDR_W-1:0] addr_bus;
    logic [ENGINES*DATA_W-1:0] data_bus;
    logic                      mem_we;
    logic [ADDR_W-1:0]         mem_addr;
    logic [DATA_W-1:0]         mem_data;
    logic                      busy;
    logic                      done;
    logic                      overrun;
    logic [1:0]                ack_err;
    logic [1:0]                timeout;

    int n_checks = 0;
    int n_pass   = 0;

    logic [ADDR_W-1:0] exp_addr;
    logic [DATA_W-1:0] exp_data;
    logic              exp_ovr;
    logic [1:0]        exp_ack;
    logic [1:0]        exp_to;

    dsp_engine_sequencer #(
        .ENGINES (ENGINES),
        .ACK_WAIT(ACK_WAIT),
        .TIMEOUT (TIMEOUT),
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W)
    ) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .start_i    (start),
        .mask_i     (mask),
        .clear_i    (clear),
        .wip_i      (wip),
        .enable_o   (enable),
        .mem2_we_i  (we),
        .mem2_addr_i(addr_bus),
        .mem2_data_i(data_bus),
        .mem_we_o   (mem_we),
        .mem_addr_o (mem_addr),
        .mem_data_o (mem_data),
        .busy_o     (busy),
        .done_o     (done),
        .overrun_o  (overrun),
        .ack_err_o  (ack_err),
        .timeout_o  (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic drive_bus(input bit all_we);
        logic [63:0] rnd;
        we = all_we ? 2'b11 : 2'($urandom);
        for (int k = 0; k < ENGINES; k++) begin
            rnd = {$urandom(), $urandom()};
            addr_bus[k*ADDR_W +: ADDR_W] = ADDR_W'($urandom());
            data_bus[k*DATA_W +: DATA_W] = DATA_W'(rnd);
        end
    endtask

    // One period: start sampled at relative edge 0. d = cycles before an engine
    // answers (>= ACK_WAIT: never), l = extra WIP cycles after the ack.
    // ovr_e/clr_e/rst_e: edge for a stray start / clear / reset (-1 none;
    // ovr_e=-2 means the DONE cycle, clr_e=-2 means slot 0's finishing edge).
    task automatic run_seq(input string tag, input logic [1:0] m,
                           input int d0, input int l0, input int d1, input int l1,
                           input int ovr_e, input int clr_e, input int rst_e,
                           input bit all_we);
        int d[2], l[2], e[2], f[2];
        bit act[2], ackf[2], tof[2];
        int t, dn, last, ovr, clr;
        logic [1:0] exp_en;
        logic exp_busy, exp_done, exp_we;
        d[0] = d0; l[0] = l0; d[1] = d1; l[1] = l1;
        t = 1;
        for (int k = 0; k < 2; k++) begin
            act[k] = m[k]; ackf[k] = 1'b0; tof[k] = 1'b0;
            e[k] = -NEVER; f[k] = -NEVER;
            if (!act[k]) begin
                t = t + 1;
            end else begin
                e[k] = t;
                if (d[k] >= ACK_WAIT) begin
                    ackf[k] = 1'b1; f[k] = t + ACK_WAIT;
                end else if (l[k] >= TIMEOUT) begin
                    tof[k] = 1'b1; f[k] = t + 1 + d[k] + TIMEOUT;
                end else begin
                    f[k] = t + 2 + d[k] + l[k];
                end
                t = f[k] + 1;
            end
        end
        dn   = t;
        ovr  = (ovr_e == -2) ? dn + 1 : ovr_e;
        clr  = (clr_e == -2) ? f[0] : clr_e;
        last = (rst_e > 0) ? rst_e : dn + 1;
        for (int r = 0; r <= last; r++) begin
            rst   = (r == rst_e);
            start = (r == 0) || (r == ovr);
            mask  = (r == 0) ? m : 2'($urandom);
            clear = (r == clr);
            for (int k = 0; k < 2; k++)
                wip[k] = act[k] && (d[k] < ACK_WAIT) && (r >= e[k] + 1 + d[k]) &&
                         (r <= e[k] + 1 + d[k] + l[k]) && (r <= f[k]);
            drive_bus(all_we);
            @(posedge clk);
            #1;
            if (r == rst_e) begin
                exp_en = '0; exp_busy = 1'b0; exp_done = 1'b0; exp_we = 1'b0;
                exp_addr = '0; exp_data = '0; exp_ovr = 1'b0; exp_ack = '0; exp_to = '0;
            end else begin
                exp_we = 1'b0;
                for (int k = 0; k < 2; k++) begin
                    if (act[k] && r >= e[k] + 1 && r <= f[k] && we[k]) begin
                        exp_we   = 1'b1;
                        exp_addr = addr_bus[k*ADDR_W +: ADDR_W];
                        exp_data = data_bus[k*DATA_W +: DATA_W];
                    end
                end
                if (r == clr) begin
                    exp_ovr = 1'b0; exp_ack = '0; exp_to = '0;
                end
                for (int k = 0; k < 2; k++) begin
                    if (ackf[k] && r == f[k]) exp_ack[k] = 1'b1;
                    if (tof[k] && r == f[k]) exp_to[k] = 1'b1;
                    exp_en[k] = act[k] && (r >= e[k]) && (r < f[k]);
                end
                if (r == ovr && r >= 1) exp_ovr = 1'b1;
                exp_busy = (r < dn);
                exp_done = (r == dn);
            end
            n_checks++;
            if (enable !== exp_en) $display("FAIL %s enable r=%0d got %b want %b", tag, r, enable, exp_en);
            else n_pass++;
            n_checks++;
            if (busy !== exp_busy) $display("FAIL %s busy r=%0d got %b want %b", tag, r, busy, exp_busy);
            else n_pass++;
            n_checks++;
            if (done !== exp_done) $display("FAIL %s done r=%0d got %b want %b", tag, r, done, exp_done);
            else n_pass++;
            n_checks++;
            if (mem_we !== exp_we) $display("FAIL %s mem_we r=%0d got %b want %b", tag, r, mem_we, exp_we);
            else n_pass++;
            n_checks++;
            if (mem_addr !== exp_addr) $display("FAIL %s mem_addr r=%0d got %h want %h", tag, r, mem_addr, exp_addr);
            else n_pass++;
            n_checks++;
            if (mem_data !== exp_data) $display("FAIL %s mem_data r=%0d got %h want %h", tag, r, mem_data, exp_data);
            else n_pass++;
            n_checks++;
            if (overrun !== exp_ovr) $display("FAIL %s overrun r=%0d got %b want %b", tag, r, overrun, exp_ovr);
            else n_pass++;
            n_checks++;
            if (ack_err !== exp_ack) $display("FAIL %s ack_err r=%0d got %b want %b", tag, r, ack_err, exp_ack);
            else n_pass++;
            n_checks++;
            if (timeout !== exp_to) $display("FAIL %s timeout r=%0d got %b want %b", tag, r, timeout, exp_to);
            else n_pass++;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            rst = 1'b0; start = 1'b0; clear = 1'b0; wip = '0;
            mask = 2'($urandom);
            drive_bus(1'b0);
            @(posedge clk);
            #1;
            n_checks++;
            if (enable !== 2'b00 || busy !== 1'b0 || done !== 1'b0 || mem_we !== 1'b0)
                $display("FAIL idle ctrl got en=%b busy=%b done=%b we=%b want 0", enable, busy, done, mem_we);
            else n_pass++;
            n_checks++;
            if (mem_addr !== exp_addr || mem_data !== exp_data)
                $display("FAIL idle hold got %h/%h want %h/%h", mem_addr, mem_data, exp_addr, exp_data);
            else n_pass++;
            n_checks++;
            if (overrun !== exp_ovr || ack_err !== exp_ack || timeout !== exp_to)
                $display("FAIL idle flags got %b/%b/%b want %b/%b/%b", overrun, ack_err, timeout,
                         exp_ovr, exp_ack, exp_to);
            else n_pass++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; clear = 1'b0; wip = 2'b11;
        for (int i = 0; i < 3; i++) begin
            start = 1'b1; mask = 2'b11;
            drive_bus(1'b1);
            @(posedge clk);
            #1;
            n_checks++;
            if ({enable, busy, done, mem_we, overrun, ack_err, timeout} !== 10'd0 ||
                mem_addr !== '0 || mem_data !== '0)
                $display("FAIL reset got en=%b busy=%b done=%b we=%b a=%h d=%h flags=%b%b%b want all 0",
                         enable, busy, done, mem_we, mem_addr, mem_data, overrun, ack_err, timeout);
            else n_pass++;
        end
        exp_addr = '0; exp_data = '0; exp_ovr = 1'b0; exp_ack = '0; exp_to = '0;
        idle(2);
    endtask

    task automatic test_both_engines();
        run_seq("both", 2'b11, 0, 40, 1, 30, -1, -1, -1, 1'b0);
        idle(2);
    endtask

    task automatic test_skip_slot();
        run_seq("skip0", 2'b10, 0, 0, 2, 10, -1, -1, -1, 1'b0);
        run_seq("skip1", 2'b01, 3, 5, 0, 0, -1, -1, -1, 1'b0);
        run_seq("none", 2'b00, 0, 0, 0, 0, -1, -1, -1, 1'b0);
        idle(1);
    endtask

    task automatic test_ack_err();
        run_seq("ackerr", 2'b11, NEVER, 0, ACK_WAIT - 1, 5, -1, -1, -1, 1'b0);
        run_seq("ack_clear", 2'b10, 0, 0, 2, 3, -1, 2, -1, 1'b0);
        run_seq("clear_vs_set", 2'b01, NEVER, 0, 0, 0, -1, -2, -1, 1'b0);
        idle(1);
    endtask

    task automatic test_timeout();
        run_seq("timeout", 2'b11, 0, NEVER, 0, TIMEOUT - 1, -1, -1, -1, 1'b0);
        run_seq("to_clear", 2'b00, 0, 0, 0, 0, -1, 1, -1, 1'b0);
        idle(1);
    endtask

    task automatic test_write_mux_overrun();
        run_seq("wr_ovr", 2'b11, 1, 20, 0, 15, 12, -1, -1, 1'b1);
        run_seq("ovr_in_done", 2'b01, 0, 5, 0, 0, -2, 1, -1, 1'b1);
        run_seq("after_done", 2'b11, 0, 3, 0, 3, -1, 4, -1, 1'b1);
        idle(1);
    endtask

    task automatic test_back_to_back();
        int ov, cl;
        for (int i = 0; i < 10; i++) begin
            ov = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 20)) : -1;
            cl = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 20)) : -1;
            run_seq("random", 2'($urandom),
                    int'($urandom_range(0, ACK_WAIT + 1)), int'($urandom_range(0, TIMEOUT + 3)),
                    int'($urandom_range(0, ACK_WAIT + 1)), int'($urandom_range(0, TIMEOUT + 3)),
                    ov, cl, -1, 1'($urandom));
        end
        idle(2);
    endtask

    task automatic test_reset_mid_run();
        run_seq("pre_rst", 2'b01, NEVER, 0, 0, 0, -1, -1, -1, 1'b0);
        run_seq("rst_mid", 2'b11, 0, 40, 0, 10, -1, -1, 10, 1'b1);
        idle(2);
        run_seq("post_rst", 2'b11, 0, 5, 1, 6, -1, -1, -1, 1'b0);
        idle(1);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; mask = '0; clear = 1'b0; wip = '0;
        we = '0; addr_bus = '0; data_bus = '0;
        test_reset();
        test_both_engines();
        test_skip_slot();
        test_ack_err();
        test_timeout();
        test_write_mux_overrun();
        test_back_to_back();
        test_reset_mid_run();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
